// File: rtl/muldiv_ctrl_pkg.sv
// ============================================================================
// muldiv_ctrl_pkg : shared op/state encodings and helpers for the mul/div unit
// Rev 1.0
// ============================================================================
`default_nettype none

package muldiv_ctrl_pkg;

    localparam int DEFAULT_W = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    function automatic logic op_is_div(input op_e o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input op_e o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_step.sv
// ============================================================================
// muldiv_step : one combinational shift-add multiply or restoring divide step
// Rev 1.0
// ============================================================================
`default_nettype none

module muldiv_step #(
    parameter int W = 32
) (
    input  logic         div_i,
    input  logic [W-1:0] acc_i,
    input  logic [W-1:0] q_i,
    input  logic [W-1:0] operand_i,
    output logic [W-1:0] acc_o,
    output logic [W-1:0] q_o
);

    logic [W:0]   w_sum;
    logic [W:0]   w_shifted;
    logic [W-1:0] w_diff;

    always_comb begin
        w_sum     = {1'b0, acc_i} + {1'b0, operand_i};
        w_shifted = {acc_i, q_i[W-1]};
        // the true difference is always < 2**W whenever it is taken
        w_diff    = w_shifted[W-1:0] - operand_i;
        acc_o     = acc_i;
        q_o       = q_i;
        if (div_i) begin
            if (w_shifted >= {1'b0, operand_i}) begin
                acc_o = w_diff;
                q_o   = {q_i[W-2:0], 1'b1};
            end else begin
                acc_o = w_shifted[W-1:0];
                q_o   = {q_i[W-2:0], 1'b0};
            end
        end else begin
            if (q_i[0]) begin
                acc_o = w_sum[W:1];
                q_o   = {w_sum[0], q_i[W-1:1]};
            end else begin
                acc_o = {1'b0, acc_i[W-1:1]};
                q_o   = {acc_i[0], q_i[W-1:1]};
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/muldiv_ctrl.sv
// ============================================================================
// muldiv_ctrl : multi-cycle sequencer for MULT/MULTU/DIV/DIVU with HI/LO regs
// Optional abort port enabled by defining MULDIV_ABORT_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int W     = DEFAULT_W,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] rs_val,
    input  logic [W-1:0] rt_val,
    input  logic         hi_we,
    input  logic         lo_we,
    input  logic [W-1:0] wdata,
`ifdef MULDIV_ABORT_EN
    input  logic         abort,
`endif
    output logic         busy,
    output logic         done,
    output logic         dbz,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    state_e         state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]   acc_q, q_q, opnd_q;
    logic           sign_a_q, sign_b_q, div_q;
    logic           busy_q, done_q, dbz_q;
    logic [W-1:0]   hi_q, lo_q;

    logic [W-1:0]   acc_d, q_d;

    op_e            w_op;
    logic           w_signed, w_div, w_sign_a, w_sign_b;
    logic [W-1:0]   w_mag_a, w_mag_b;
    logic           w_accept, w_mt_ok, w_abort;
    logic [2*W-1:0] w_prod, w_prod_fix;
    logic [W-1:0]   w_quot_fix, w_rem_fix;

    assign w_op     = op_e'(op);
    assign w_signed = op_is_signed(w_op);
    assign w_div    = op_is_div(w_op);
    assign w_sign_a = w_signed & rs_val[W-1];
    assign w_sign_b = w_signed & rt_val[W-1];
    assign w_mag_a  = w_sign_a ? -rs_val : rs_val;
    assign w_mag_b  = w_sign_b ? -rt_val : rt_val;

    assign w_accept = (state_q == S_IDLE) && start;
    assign w_mt_ok  = ((state_q == S_IDLE) || (state_q == S_DONE)) && !start;

`ifdef MULDIV_ABORT_EN
    assign w_abort  = abort && ((state_q == S_RUN) || (state_q == S_FIX));
`else
    assign w_abort  = 1'b0;
`endif

    assign w_prod     = {acc_q, q_q};
    assign w_prod_fix = (sign_a_q ^ sign_b_q) ? -w_prod : w_prod;
    assign w_quot_fix = (sign_a_q ^ sign_b_q) ? -q_q : q_q;
    assign w_rem_fix  = sign_a_q ? -acc_q : acc_q;

    muldiv_step #(
        .W (W)
    ) u_step (
        .div_i     (div_q),
        .acc_i     (acc_q),
        .q_i       (q_q),
        .operand_i (opnd_q),
        .acc_o     (acc_d),
        .q_o       (q_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            q_q      <= '0;
            opnd_q   <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            div_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            if (w_mt_ok && hi_we) hi_q <= wdata;
            if (w_mt_ok && lo_we) lo_q <= wdata;
            case (state_q)
                S_IDLE: begin
                    if (w_accept) begin
                        dbz_q    <= 1'b0;
                        sign_a_q <= w_sign_a;
                        sign_b_q <= w_sign_b;
                        div_q    <= w_div;
                        cnt_q    <= CNT_W'(W);
                        acc_q    <= '0;
                        q_q      <= w_mag_a;
                        opnd_q   <= w_mag_b;
                        // divide by zero commits immediately, bypassing the iterations
                        if (w_div && (rt_val == '0)) begin
                            hi_q    <= rs_val;
                            lo_q    <= '1;
                            dbz_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_abort) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        acc_q <= acc_d;
                        q_q   <= q_d;
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == CNT_W'(1)) state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    busy_q <= 1'b0;
                    if (w_abort) begin
                        state_q <= S_IDLE;
                    end else begin
                        if (div_q) begin
                            hi_q <= w_rem_fix;
                            lo_q <= w_quot_fix;
                        end else begin
                            hi_q <= w_prod_fix[2*W-1:W];
                            lo_q <= w_prod_fix[W-1:0];
                        end
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q | w_accept;
    assign done = done_q;
    assign dbz  = dbz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

`default_nettype wire
